// File: rtl/sub_serial_pkg.sv
// Shared constants and helpers for the digit-serial subtractor.
// The optional signed-overflow output is enabled with SUB_SERIAL_OVF_EN.
package sub_serial_pkg;

  localparam int unsigned SUB_WIDTH = 32;
  localparam int unsigned SUB_CHUNK = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Step-counter width; kept at least one bit so a single-step build still elaborates.
  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned chunk);
    int unsigned n;
    n = width / chunk;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sub_serial_chunk.sv
// CHUNK-bit ripple-carry adder slice reused every step of the serial subtractor.
module sub_chunk
  import sub_serial_pkg::*;
#(
  parameter int unsigned CHUNK = SUB_CHUNK
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);

  logic carry;

  always_comb begin
    carry = cin_i;
    sum_o = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule

// File: rtl/sub_serial.sv
// Digit-serial subtractor: a - b computed as a + ~b + 1, CHUNK bits per cycle, LSB first.
// Define SUB_SERIAL_OVF_EN to add the registered signed-overflow output.
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH,
  parameter int unsigned CHUNK = SUB_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SUB_SERIAL_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned CW = cnt_width(WIDTH, CHUNK);
  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if ((WIDTH % CHUNK) != 0) begin : g_chunk_check
    $error("sub_serial: CHUNK must divide WIDTH");
  end

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
`ifdef SUB_SERIAL_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [IW-1:0]    base_c;
  logic [CHUNK-1:0] sum_c;
  logic             cout_c;

  assign base_c = IW'(32'(cnt_q) * CHUNK);

  sub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i   (a_q[base_c +: CHUNK]),
    .b_i   (nb_q[base_c +: CHUNK]),
    .cin_i (carry_q),
    .sum_o (sum_c),
    .cout_o(cout_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      nb_q     <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      nb_q     <= nb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SUB_SERIAL_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    nb_d     = nb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SUB_SERIAL_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_BUSY;
          a_d     = a;
          nb_d    = ~b;
          carry_d = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        diff_d[base_c +: CHUNK] = sum_c;
        carry_d = cout_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d  = ST_DONE;
          cnt_d    = '0;
          borrow_d = ~cout_c;
`ifdef SUB_SERIAL_OVF_EN
          // Operand signs differ and the result sign departs from the minuend's.
          ovf_d = (a_q[WIDTH-1] != ~nb_q[WIDTH-1]) && (sum_c[CHUNK-1] != a_q[WIDTH-1]);
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
`ifdef SUB_SERIAL_OVF_EN
  assign overflow  = ovf_q;
`endif

endmodule
